// File: rtl/resample_pkg.sv
// Shared resample definitions: rate bit positions, rate class encoding and
// detector state type, used by the rate detector and the resample pipeline.
package resample_pkg;

    localparam int RATE_32      = 0;
    localparam int RATE_441     = 1;
    localparam int RATE_48      = 2;
    localparam int RATE_96      = 3;
    localparam int RATE_192     = 4;
    localparam int NUM_RATE_CLS = 5;

    typedef enum logic [2:0] {
        CLS_32   = 3'd0,
        CLS_441  = 3'd1,
        CLS_48   = 3'd2,
        CLS_96   = 3'd3,
        CLS_192  = 3'd4,
        CLS_NONE = 3'd7
    } rate_cls_t;

    typedef enum logic {
        IDLE_COUNT = 1'b0,
        EVAL       = 1'b1
    } detect_state_t;

    function automatic logic [NUM_RATE_CLS-1:0] cls_to_onehot(input rate_cls_t cls);
        logic [NUM_RATE_CLS-1:0] oh;
        oh = '0;
        case (cls)
            CLS_32:  oh[RATE_32]  = 1'b1;
            CLS_441: oh[RATE_441] = 1'b1;
            CLS_48:  oh[RATE_48]  = 1'b1;
            CLS_96:  oh[RATE_96]  = 1'b1;
            CLS_192: oh[RATE_192] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/resample_rate_classify.sv
// Combinational mapping from a per-window strobe count to a rate class.
module resample_rate_classify
    import resample_pkg::*;
#(
    parameter int CNT_W  = 10,
    parameter int TH_MIN = 20,
    parameter int TH_441 = 50,
    parameter int TH_48  = 61,
    parameter int TH_96  = 96,
    parameter int TH_192 = 192,
    parameter int TH_MAX = 320
) (
    input  logic [CNT_W-1:0] count,
    output rate_cls_t        cls
);

    logic [31:0] cnt_ext;

    assign cnt_ext = 32'(count);

    // Thresholds are compared at 32 bits so TH_MAX may exceed the counter range.
    always_comb begin
        if (cnt_ext < 32'(TH_MIN) || cnt_ext >= 32'(TH_MAX)) begin
            cls = CLS_NONE;
        end else if (cnt_ext >= 32'(TH_192)) begin
            cls = CLS_192;
        end else if (cnt_ext >= 32'(TH_96)) begin
            cls = CLS_96;
        end else if (cnt_ext >= 32'(TH_48)) begin
            cls = CLS_48;
        end else if (cnt_ext >= 32'(TH_441)) begin
            cls = CLS_441;
        end else begin
            cls = CLS_32;
        end
    end

endmodule

// File: rtl/resample_rate_detector.sv
// Per-channel sample rate detector: counts strobes per window, classifies each
// channel in a serial walk and drives one-hot rate, lock and change outputs.
module resample_rate_detector
    import resample_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int NUM_CH_LOG2  = 3,
    parameter int NUM_RATE     = 5,
    parameter int WINDOW_LOG2  = 16,
    parameter int CNT_W        = 10,
    parameter int TH_MIN       = 20,
    parameter int TH_441       = 50,
    parameter int TH_48        = 61,
    parameter int TH_96        = 96,
    parameter int TH_192       = 192,
    parameter int TH_MAX       = 320,
    parameter int LOCK_WINDOWS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ack_i,
    output logic [NUM_RATE*NUM_CH-1:0] rate_o,
    output logic [NUM_CH-1:0]          locked_o,
    output logic [NUM_CH-1:0]          change_o
);

    localparam int                     STB_W    = $clog2(LOCK_WINDOWS + 1);
    localparam logic [STB_W-1:0]       STB_LOCK = STB_W'(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
    localparam logic [NUM_CH_LOG2-1:0] LAST_CH  = NUM_CH_LOG2'(NUM_CH - 1);

    logic [WINDOW_LOG2-1:0] win_cnt;
    logic                   terminal;

    logic [CNT_W-1:0] live     [NUM_CH];
    logic [CNT_W-1:0] live_nxt [NUM_CH];
    logic [CNT_W-1:0] snap     [NUM_CH];

    detect_state_t          state;
    logic [NUM_CH_LOG2-1:0] ch_idx;

    rate_cls_t        pending [NUM_CH];
    logic [STB_W-1:0] stable  [NUM_CH];

    rate_cls_t         cls;
    logic [NUM_RATE-1:0] cls_onehot;
    logic [NUM_RATE-1:0] cur_rate;
    logic [NUM_RATE-1:0] new_rate;
    logic                cur_locked;
    logic                new_locked;
    rate_cls_t           cur_pending;
    rate_cls_t           new_pending;
    logic [STB_W-1:0]    cur_stable;
    logic [STB_W-1:0]    new_stable;

    assign terminal = &win_cnt;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            live_nxt[ch] = (ack_i[ch] && live[ch] != CNT_MAX) ? live[ch] + 1'b1 : live[ch];
        end
    end

    // The terminal cycle's strobe lands in the snapshot while the live counter restarts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                live[ch] <= '0;
                snap[ch] <= '0;
            end
        end else begin
            win_cnt <= win_cnt + 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (terminal) begin
                    snap[ch] <= live_nxt[ch];
                    live[ch] <= '0;
                end else begin
                    live[ch] <= live_nxt[ch];
                end
            end
        end
    end

    resample_rate_classify #(
        .CNT_W  (CNT_W),
        .TH_MIN (TH_MIN),
        .TH_441 (TH_441),
        .TH_48  (TH_48),
        .TH_96  (TH_96),
        .TH_192 (TH_192),
        .TH_MAX (TH_MAX)
    ) u_classify (
        .count (snap[ch_idx]),
        .cls   (cls)
    );

    assign cls_onehot = cls_to_onehot(cls);

    always_comb begin
        cur_rate    = rate_o[ch_idx*NUM_RATE +: NUM_RATE];
        cur_locked  = locked_o[ch_idx];
        cur_pending = pending[ch_idx];
        cur_stable  = stable[ch_idx];
        new_rate    = cur_rate;
        new_locked  = cur_locked;
        new_pending = cur_pending;
        new_stable  = cur_stable;
        if (cls == CLS_NONE) begin
            new_pending = CLS_NONE;
            new_stable  = '0;
            new_locked  = 1'b0;
            new_rate    = '0;
        end else if (cls != cur_pending) begin
            // A new candidate mutes the channel unless it already matches the output.
            new_pending = cls;
            new_stable  = STB_W'(1);
            if (cls_onehot != cur_rate) begin
                new_locked = 1'b0;
                new_rate   = '0;
            end
        end else if (!cur_locked) begin
            if (cur_stable < STB_LOCK) begin
                new_stable = cur_stable + 1'b1;
            end
            if (new_stable == STB_LOCK) begin
                new_locked = 1'b1;
                new_rate   = cls_onehot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE_COUNT;
            ch_idx   <= '0;
            rate_o   <= '0;
            locked_o <= '0;
            change_o <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pending[ch] <= CLS_32;
                stable[ch]  <= '0;
            end
        end else begin
            change_o <= '0;
            case (state)
                IDLE_COUNT: begin
                    if (terminal) begin
                        state  <= EVAL;
                        ch_idx <= '0;
                    end
                end
                EVAL: begin
                    pending[ch_idx]                       <= new_pending;
                    stable[ch_idx]                        <= new_stable;
                    locked_o[ch_idx]                      <= new_locked;
                    rate_o[ch_idx*NUM_RATE +: NUM_RATE]   <= new_rate;
                    change_o[ch_idx]                      <= (new_rate != cur_rate);
                    if (ch_idx == LAST_CH) begin
                        state  <= IDLE_COUNT;
                        ch_idx <= '0;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE_COUNT;
                    ch_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resample_rate_detector.sv
// Directed bench for resample_rate_detector: one table row per window of
// per-channel strobe counts with hand-derived rate/lock/change expectations.
module tb_resample_rate_detector;

    localparam int NUM_CH   = 8;
    localparam int NUM_RATE = 5;
    localparam int WLOG     = 11;
    localparam int WIN      = 1 << WLOG;
    localparam int NROWS    = 10;

    localparam logic [4:0] RZ   = 5'b00000;
    localparam logic [4:0] R32  = 5'b00001;
    localparam logic [4:0] R441 = 5'b00010;
    localparam logic [4:0] R48  = 5'b00100;
    localparam logic [4:0] R96  = 5'b01000;
    localparam logic [4:0] R192 = 5'b10000;

    typedef struct packed {
        logic [7:0][11:0] cnt;
        logic [7:0][4:0]  rate;
        logic [7:0]       locked;
        logic [7:0]       change;
    } vec_t;

    vec_t tbl [NROWS];
    vec_t relock_a;
    vec_t relock_b;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_CH-1:0]          ack_i = '0;
    logic [NUM_RATE*NUM_CH-1:0] rate_o;
    logic [NUM_CH-1:0]          locked_o;
    logic [NUM_CH-1:0]          change_o;

    int pos = 0;
    int nChecks = 0;
    int nFail = 0;
    int cfg    [NUM_CH];
    int chgCnt [NUM_CH];
    int chgPos [NUM_CH];

    always #5 clk = ~clk;

    resample_rate_detector #(
        .WINDOW_LOG2 (WLOG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ack_i    (ack_i),
        .rate_o   (rate_o),
        .locked_o (locked_o),
        .change_o (change_o)
    );

    function automatic logic [7:0][11:0] c8(input int a0, input int a1, input int a2, input int a3,
                                            input int a4, input int a5, input int a6, input int a7);
        logic [7:0][11:0] v;
        v[0] = 12'(a0); v[1] = 12'(a1); v[2] = 12'(a2); v[3] = 12'(a3);
        v[4] = 12'(a4); v[5] = 12'(a5); v[6] = 12'(a6); v[7] = 12'(a7);
        return v;
    endfunction

    function automatic logic [7:0][4:0] r8(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                           input logic [4:0] a3, input logic [4:0] a4, input logic [4:0] a5,
                                           input logic [4:0] a6, input logic [4:0] a7);
        logic [7:0][4:0] v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobes sit at the end of each window so a count set at pos 16 covers the whole window.
    task automatic stepCycle();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ack_i[ch] = (pos >= WIN - cfg[ch]);
        end
        @(posedge clk);
        @(negedge clk);
        pos = (pos + 1) % WIN;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (change_o[ch]) begin
                chgCnt[ch]++;
                chgPos[ch] = pos;
            end
        end
    endtask

    task automatic clearChanges();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            chgCnt[ch] = 0;
            chgPos[ch] = -1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cfg[ch] = int'(v.cnt[ch]);
        end
        clearChanges();
        repeat (WIN) stepCycle();
    endtask

    task automatic checkRow(input string tag, input vec_t v);
        logic [7:0] once;
        logic [7:0] multi;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            once[ch]  = (chgCnt[ch] == 1);
            multi[ch] = (chgCnt[ch] > 1);
        end
        checkOutput({tag, " rate"}, 64'(rate_o), 64'(v.rate));
        checkOutput({tag, " locked"}, 64'(locked_o), 64'(v.locked));
        checkOutput({tag, " change"}, 64'(once), 64'(v.change));
        checkOutput({tag, " change_multi"}, 64'(multi), 64'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) stepCycle();
        rst = 1'b0;
        pos = 0;
    endtask

    initial begin
        #(10 * 60000);
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{cnt: c8(64, 20, 128, 95, 319, 256, 2048, 1),
                   rate: r8(RZ, RZ, RZ, RZ, RZ, RZ, RZ, RZ), locked: 8'b0000_0000, change: 8'b0000_0000};
        tbl[1] = '{cnt: c8(64, 20, 128, 95, 319, 256, 2048, 1),
                   rate: r8(R48, R32, R96, R48, R192, R192, RZ, RZ), locked: 8'b0011_1111, change: 8'b0011_1111};
        tbl[2] = '{cnt: c8(64, 19, 58, 96, 320, 256, 1124, 20),
                   rate: r8(R48, RZ, RZ, RZ, RZ, R192, RZ, RZ), locked: 8'b0010_0001, change: 8'b0001_1110};
        tbl[3] = '{cnt: c8(64, 20, 58, 96, 320, 0, 1124, 20),
                   rate: r8(R48, RZ, R441, R96, RZ, RZ, RZ, R32), locked: 8'b1000_1101, change: 8'b1010_1100};
        tbl[4] = '{cnt: c8(64, 20, 58, 191, 319, 0, 100, 20),
                   rate: r8(R48, R32, R441, R96, RZ, RZ, RZ, R32), locked: 8'b1000_1111, change: 8'b0000_0010};
        tbl[5] = '{cnt: c8(64, 49, 58, 192, 319, 0, 100, 20),
                   rate: r8(R48, R32, R441, RZ, R192, RZ, R96, R32), locked: 8'b1101_0111, change: 8'b0101_1000};
        tbl[6] = '{cnt: c8(64, 50, 58, 192, 319, 0, 100, 20),
                   rate: r8(R48, RZ, R441, R192, R192, RZ, R96, R32), locked: 8'b1101_1101, change: 8'b0000_1010};
        tbl[7] = '{cnt: c8(64, 50, 58, 192, 319, 0, 100, 20),
                   rate: r8(R48, R441, R441, R192, R192, RZ, R96, R32), locked: 8'b1101_1111, change: 8'b0000_0010};
        tbl[8] = '{cnt: c8(64, 49, 58, 192, 319, 0, 100, 20),
                   rate: r8(R48, RZ, R441, R192, R192, RZ, R96, R32), locked: 8'b1101_1101, change: 8'b0000_0010};
        tbl[9] = '{cnt: c8(64, 49, 58, 192, 319, 0, 100, 20),
                   rate: r8(R48, R32, R441, R192, R192, RZ, R96, R32), locked: 8'b1101_1111, change: 8'b0000_0010};
        relock_a = '{cnt: c8(64, 64, 64, 64, 64, 64, 64, 64),
                     rate: r8(RZ, RZ, RZ, RZ, RZ, RZ, RZ, RZ), locked: 8'h00, change: 8'h00};
        relock_b = '{cnt: c8(64, 64, 64, 64, 64, 64, 64, 64),
                     rate: r8(R48, R48, R48, R48, R48, R48, R48, R48), locked: 8'hff, change: 8'hff};

        for (int ch = 0; ch < NUM_CH; ch++) begin
            cfg[ch] = int'(tbl[0].cnt[ch]);
        end
        clearChanges();
        @(negedge clk);
        doReset();
        checkOutput("reset rate", 64'(rate_o), 64'h0);
        checkOutput("reset locked", 64'(locked_o), 64'h0);
        checkOutput("reset change", 64'(change_o), 64'h0);
        repeat (16) stepCycle();

        for (int k = 0; k < NROWS; k++) begin
            applyStimulus(tbl[k]);
            checkRow($sformatf("window%0d", k + 1), tbl[k]);
        end

        // Reset lands on the EVAL cycle of channel 3 while most channels are locked.
        while (pos != 3) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("midreset rate", 64'(rate_o), 64'h0);
        checkOutput("midreset locked", 64'(locked_o), 64'h0);
        checkOutput("midreset change", 64'(change_o), 64'h0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cfg[ch] = 64;
        end
        repeat (2) stepCycle();
        rst = 1'b0;
        pos = 0;
        repeat (16) stepCycle();

        applyStimulus(relock_a);
        checkRow("relock1", relock_a);
        applyStimulus(relock_b);
        checkRow("relock2", relock_b);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checkOutput($sformatf("relock2 ch%0d change position", ch), 64'(chgPos[ch]), 64'(ch + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/resample_rate_detector.md
Name: resample_rate_detector

Overview:
- Measures each input channel's sample rate by counting input-valid strobes over a fixed clock window.
- Classifies the count into one of the supported rates: 32k, 44.1k, 48k, 96k, 192k.
- Drives the per-channel one-hot rate vector that configures the resampling pipeline, plus per-channel lock flags.
- Sits between the input receivers and the resample pipeline. A rate change mutes the channel until the new rate is confirmed.

Parameters:
- NUM_CH, 8, number of channels.
- NUM_CH_LOG2, 3, width of the channel index.
- NUM_RATE, 5, number of rate classes; one-hot width per channel.
- WINDOW_LOG2, 16, window length is 2^WINDOW_LOG2 clocks (1.333 ms at 49.152 MHz). Must satisfy 2^WINDOW_LOG2 > NUM_CH+2.
- CNT_W, 10, width of the strobe counter; saturates at 2^CNT_W-1.
- TH_MIN, 20, counts below this mean no signal.
- TH_441, 50, lower bound of 44.1k; counts from TH_MIN to TH_441-1 are 32k.
- TH_48, 61, lower bound of 48k.
- TH_96, 96, lower bound of 96k.
- TH_192, 192, lower bound of 192k.
- TH_MAX, 320, counts of TH_MAX or more are invalid.
- LOCK_WINDOWS, 2, number of consecutive identical classifications needed to lock.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ack_i  in  NUM_CH  per-channel input sample strobe; one sample per high cycle.
- rate_o  out  NUM_RATE*NUM_CH  per-channel one-hot rate. Bit order within a channel: 0=32k, 1=44.1k, 2=48k, 3=96k, 4=192k. All zero when not locked.
- locked_o  out  NUM_CH  channel has a confirmed rate.
- change_o  out  NUM_CH  one-cycle pulse when a channel's rate_o changes value, including to or from zero.

Behaviour:
- Reset: all outputs 0. Window counter, live counters, snapshots, pending class and stable count are all 0. FSM state is IDLE_COUNT.
- Window counter: free-running, WINDOW_LOG2 bits. The terminal cycle is the one where the counter equals all-ones.
- Live counters (one per channel): increment on each ack_i high cycle and saturate at 2^CNT_W-1.
  - On the terminal cycle, the live value (including that cycle's ack) is copied into snap[ch].
  - On the same cycle the live counter is cleared to 0, so no ack is ever lost or double-counted.
- FSM:
  - IDLE_COUNT: on the terminal cycle go to EVAL with ch_idx=0.
  - EVAL: one channel per clock using a single shared classifier. Increment ch_idx; after ch_idx = NUM_CH-1 return to IDLE_COUNT. Counting continues during EVAL.
- Classification of snap[ch]:
  - < TH_MIN, or >= TH_MAX: class NONE.
  - Otherwise: the highest threshold not exceeding the count, giving 32k / 44.1k / 48k / 96k / 192k.
- Per-channel update in EVAL, registered so outputs change the cycle after that channel's EVAL cycle:
  - cls == NONE: pending=NONE, stable=0, locked=0, rate=0.
  - cls != pending: pending=cls, stable=1. If cls differs from the current rate, drop locked and set rate=0 (mute) immediately.
  - cls == pending and not locked: stable=stable+1, saturating at LOCK_WINDOWS. When stable reaches LOCK_WINDOWS, set locked=1 and rate=onehot(cls).
  - cls == pending and locked: no change.
- change_o[ch] pulses exactly in the cycle where rate_o[ch] takes a new value.
- Latency: a stable rate locks at the end of the LOCK_WINDOWS-th full window, plus ch_idx+1 clocks.
- Reset during EVAL: aborts the walk and returns to the reset state. No partial output updates persist.
- Simultaneous ack on all channels on the terminal cycle: each channel is counted once into the closing window.

Decomposition:
- Shared package resample_pkg:
  - RATE_32/RATE_441/RATE_48/RATE_96/RATE_192 bit indices (0..4), which the resample pipeline also uses.
  - 3-bit class encoding with CLS_NONE=7.
  - Function cls_to_onehot.
- One natural sub-module: resample_rate_classify, a combinational comparator from count to class, instantiated once and shared by the EVAL walk.

Test Plan:
- Steady 48k (ack every 1024 clocks): after reset, ch0 locked_o=1, rate_o[4:0]=5'b00100, and change_o pulses once, all during window 2's EVAL. No further change_o.
- Rate switch: ch2 goes from 96k (every 512 clocks) to 44.1k (every 1115 clocks).
  - In the first affected window, rate_o[14:10]=0 and locked_o[2]=0 with a change_o pulse.
  - One window later, rate_o[14:10]=5'b00010.
- Signal loss: stop ack_i[5] while locked at 192k. The first window with count < 20 gives rate_o[29:25]=0 and locked_o[5]=0.
- Boundaries with forced counts (per window):
  - 19 gives NONE; 20 gives 32k; 49 gives 32k; 50 gives 44.1k.
  - 319 gives 192k; 320 gives NONE.
  - ack held high continuously: counter saturates at 1023, giving NONE.
- Terminal-cycle ack: ack on the terminal cycle only, for all channels. Each channel's snap includes it and the next window starts at 0. Check with a scoreboard count.
- Mid-EVAL reset: assert rst while ch_idx=3. All outputs 0 the next cycle, and the FSM restarts cleanly with relock after LOCK_WINDOWS windows.
